// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_arbiter
// Description : Shares one single-port framebuffer RAM between the VGA line
//               prefetcher and a CPU requester. A line request copies
//               LINE_WORDS words of the requested line into the display line
//               buffer, and display fetches always have priority. CPU reads
//               and writes are served between fetches, two cycles each. A
//               sticky flag records a line request that arrives while the
//               previous fetch is still issuing words.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLOCK_50      in   system clock, rising edge
//   RESET_N       in   synchronous active-low reset
//   line_req      in   one-cycle pulse: fetch line line_num
//   line_num      in   line to fetch, sampled with line_req
//   lb_we         out  line-buffer write strobe
//   lb_addr       out  line-buffer word index
//   lb_data       out  line-buffer write data
//   cpu_req       in   CPU request, held until cpu_ack
//   cpu_we        in   1 = write, 0 = read
//   cpu_addr      in   CPU word address
//   cpu_wdata     in   CPU write data
//   cpu_ack       out  one-cycle completion pulse
//   cpu_rdata     out  read data, valid with cpu_ack
//   mem_addr      out  RAM address
//   mem_we        out  RAM write enable
//   mem_wdata     out  RAM write data
//   mem_rdata     in   RAM read data, one cycle after its address
//   fetch_busy    out  high while a line fetch is issuing or draining
//   underrun      out  sticky fetch overrun flag
//   underrun_clr  in   clears underrun (a simultaneous new overrun wins)
// ============================================================================
module vga_fb_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int LINE_WORDS = 80,
   parameter int LB_AW      = 7,
   parameter int LINE_W     = 9
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   input  logic              line_req,
   input  logic [LINE_W-1:0] line_num,
   output logic              lb_we,
   output logic [LB_AW-1:0]  lb_addr,
   output logic [DATA_W-1:0] lb_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              fetch_busy,
   output logic              underrun,
   input  logic              underrun_clr
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      DRAIN     = 3'd2,
      CPU_ISSUE = 3'd3,
      CPU_ACK   = 3'd4
   } state_t;

   localparam logic [LB_AW-1:0]  c_LAST_IDX   = LB_AW'(LINE_WORDS - 1);
   localparam logic [ADDR_W-1:0] c_LINE_WORDS = ADDR_W'(LINE_WORDS);

   state_t              r_state, w_state_nxt;
   logic [LB_AW-1:0]    r_idx, w_idx_nxt;
   logic [LINE_W-1:0]   r_line;
   logic                r_pending;
   logic                r_lb_pend;
   logic [LB_AW-1:0]    r_lb_idx;
   logic                r_underrun;
   logic                w_enter_fetch;
   logic                w_abort;
   logic [ADDR_W-1:0]   w_fetch_addr;

   // Arithmetic modulo 2^ADDR_W gives the required truncation directly.
   assign w_fetch_addr = ADDR_W'(r_line) * c_LINE_WORDS + ADDR_W'(r_idx);

   // A line request while words are still being issued kills that fetch.
   assign w_abort = (r_state == FETCH) && line_req;

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_enter_fetch = 1'b0;
      mem_addr      = '0;
      mem_we        = 1'b0;
      mem_wdata     = '0;
      cpu_ack       = 1'b0;
      cpu_rdata     = '0;
      case (r_state)
         IDLE, DRAIN, CPU_ACK: begin
            if (r_state == CPU_ACK) begin
               cpu_ack   = 1'b1;
               cpu_rdata = cpu_we ? '0 : mem_rdata;
            end
            if (line_req || r_pending) begin
               w_state_nxt   = FETCH;
               w_idx_nxt     = '0;
               w_enter_fetch = 1'b1;
            end else if (cpu_req) begin
               w_state_nxt = CPU_ISSUE;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         FETCH: begin
            mem_addr = w_fetch_addr;
            if (line_req) begin
               // Restart on the newly latched line next cycle.
               w_idx_nxt     = '0;
               w_enter_fetch = 1'b1;
            end else if (r_idx == c_LAST_IDX) begin
               w_state_nxt = DRAIN;
            end else begin
               w_idx_nxt = r_idx + 1'b1;
            end
         end
         CPU_ISSUE: begin
            mem_addr    = cpu_addr;
            mem_we      = cpu_we;
            mem_wdata   = cpu_wdata;
            w_state_nxt = CPU_ACK;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         r_line     <= '0;
         r_pending  <= 1'b0;
         r_lb_pend  <= 1'b0;
         r_lb_idx   <= '0;
         r_underrun <= 1'b0;
      end else begin
         if (line_req) begin
            r_line <= line_num;
         end
         // Only CPU_ISSUE cannot dispatch immediately, so only it defers.
         if (w_enter_fetch) begin
            r_pending <= 1'b0;
         end else if ((r_state == CPU_ISSUE) && line_req) begin
            r_pending <= 1'b1;
         end
         // The word issued in this cycle lands in the line buffer next cycle,
         // unless this fetch is being aborted.
         r_lb_pend <= (r_state == FETCH) && !w_abort;
         r_lb_idx  <= r_idx;
         if (w_abort) begin
            r_underrun <= 1'b1;
         end else if (underrun_clr) begin
            r_underrun <= 1'b0;
         end
      end
   end

   assign lb_we      = r_lb_pend;
   assign lb_addr    = r_lb_pend ? r_lb_idx : '0;
   assign lb_data    = r_lb_pend ? mem_rdata : '0;
   assign fetch_busy = (r_state == FETCH) || (r_state == DRAIN);
   assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fb_arbiter
// Description : Directed self-checking bench for vga_fb_arbiter with a
//               synchronous-read framebuffer RAM model (RAM[i] = i at start).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 16;
   localparam int LINE_WORDS = 80;
   localparam int LB_AW      = 7;
   localparam int LINE_W     = 9;

   logic              CLOCK_50 = 1'b0;
   logic              RESET_N;
   logic              line_req;
   logic [LINE_W-1:0] line_num;
   logic              lb_we;
   logic [LB_AW-1:0]  lb_addr;
   logic [DATA_W-1:0] lb_data;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              fetch_busy;
   logic              underrun;
   logic              underrun_clr;

   logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

   int n_checks = 0;
   int n_pass   = 0;

   vga_fb_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS),
      .LB_AW(LB_AW), .LINE_W(LINE_W)
   ) dut (
      .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
      .line_req(line_req), .line_num(line_num),
      .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .fetch_busy(fetch_busy),
      .underrun(underrun), .underrun_clr(underrun_clr)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Single-port RAM: read data appears the cycle after the address.
   always @(posedge CLOCK_50) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   // Called in the first FETCH cycle; checks all words plus DRAIN, then
   // returns one cycle after DRAIN.
   task automatic expect_fetch(input int line);
      for (int k = 0; k <= LINE_WORDS; k++) begin
         chk("fetch_busy", fetch_busy, 1);
         chk("mem_we_fetch", mem_we, 0);
         if (k < LINE_WORDS) chk("mem_addr_fetch", mem_addr, line*LINE_WORDS + k);
         else                chk("mem_addr_drain", mem_addr, 0);
         if (k == 0) begin
            chk("lb_we_first", lb_we, 0);
         end else begin
            chk("lb_we", lb_we, 1);
            chk("lb_addr", lb_addr, k - 1);
            chk("lb_data", lb_data, line*LINE_WORDS + k - 1);
         end
         tick();
      end
      chk("fetch_busy_end", fetch_busy, 0);
      chk("lb_we_end", lb_we, 0);
   endtask

   initial begin
      for (int i = 0; i < (1<<ADDR_W); i++) ram[i] = DATA_W'(i);
      RESET_N = 1'b0; line_req = 1'b0; line_num = '0; cpu_req = 1'b0;
      cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; underrun_clr = 1'b0;
      tick(); tick();
      chk("rst_state_busy", fetch_busy, 0);
      chk("rst_lb_we", lb_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_underrun", underrun, 0);
      RESET_N = 1'b1;
      tick();

      // Line 3 from IDLE.
      line_req = 1'b1; line_num = 9'd3;
      tick();
      line_req = 1'b0;
      expect_fetch(3);
      chk("idle_after_fetch_addr", mem_addr, 0);

      // CPU write then back-to-back read of 0x0005.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 16'h1234;
      tick();
      chk("wr_issue_we", mem_we, 1);
      chk("wr_issue_addr", mem_addr, 16'h0005);
      chk("wr_issue_wdata", mem_wdata, 16'h1234);
      chk("wr_issue_ack", cpu_ack, 0);
      tick();
      chk("wr_ack", cpu_ack, 1);
      chk("wr_ack_rdata", cpu_rdata, 0);
      chk("wr_ack_we", mem_we, 0);
      cpu_we = 1'b0; cpu_wdata = '0;
      tick();
      chk("rd_issue_we", mem_we, 0);
      chk("rd_issue_addr", mem_addr, 16'h0005);
      chk("rd_issue_ack", cpu_ack, 0);
      tick();
      chk("rd_ack", cpu_ack, 1);
      chk("rd_ack_rdata", cpu_rdata, 16'h1234);
      cpu_req = 1'b0;
      tick();
      chk("rd_done_ack", cpu_ack, 0);

      // cpu_req together with line_req: fetch first, ack two cycles after DRAIN.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
      line_req = 1'b1; line_num = 9'd2;
      tick();
      line_req = 1'b0;
      expect_fetch(2);
      chk("post_drain_issue_addr", mem_addr, 16'h0100);
      chk("post_drain_issue_ack", cpu_ack, 0);
      tick();
      chk("post_drain_ack", cpu_ack, 1);
      chk("post_drain_rdata", cpu_rdata, 16'h0100);
      cpu_req = 1'b0;
      tick();

      // line_req during CPU_ISSUE: ack completes, fetch of line 1 follows.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
      tick();
      chk("pend_issue_we", mem_we, 1);
      line_req = 1'b1; line_num = 9'd1;
      tick();
      line_req = 1'b0; cpu_req = 1'b0;
      chk("pend_ack", cpu_ack, 1);
      chk("pend_ack_busy", fetch_busy, 0);
      tick();
      expect_fetch(1);
      chk("pend_no_underrun", underrun, 0);

      // Overrun: line 5 interrupted at word 40 by line 7.
      line_req = 1'b1; line_num = 9'd5;
      tick();
      line_req = 1'b0;
      for (int k = 0; k < 40; k++) tick();
      chk("ovr_word40_addr", mem_addr, 5*LINE_WORDS + 40);
      chk("ovr_word39_lb", lb_addr, 39);
      chk("ovr_pre_underrun", underrun, 0);
      line_req = 1'b1; line_num = 9'd7;
      tick();
      line_req = 1'b0;
      chk("ovr_underrun", underrun, 1);
      expect_fetch(7);
      chk("ovr_sticky", underrun, 1);

      // underrun_clr alone clears.
      underrun_clr = 1'b1;
      tick();
      underrun_clr = 1'b0;
      chk("clr_alone", underrun, 0);

      // underrun_clr with a new overrun: set wins.
      line_req = 1'b1; line_num = 9'd0;
      tick();
      line_req = 1'b1; line_num = 9'd4; underrun_clr = 1'b1;
      tick();
      line_req = 1'b0; underrun_clr = 1'b0;
      chk("clr_vs_set", underrun, 1);
      chk("clr_vs_set_addr", mem_addr, 4*LINE_WORDS);
      for (int k = 0; k < 5; k++) tick();
      chk("mid_fetch_lb_we", lb_we, 1);

      // Reset mid-fetch.
      RESET_N = 1'b0;
      tick();
      chk("rst_mid_lb_we", lb_we, 0);
      chk("rst_mid_lb_addr", lb_addr, 0);
      chk("rst_mid_lb_data", lb_data, 0);
      chk("rst_mid_mem_addr", mem_addr, 0);
      chk("rst_mid_mem_we", mem_we, 0);
      chk("rst_mid_mem_wdata", mem_wdata, 0);
      chk("rst_mid_cpu_ack", cpu_ack, 0);
      chk("rst_mid_cpu_rdata", cpu_rdata, 0);
      chk("rst_mid_busy", fetch_busy, 0);
      chk("rst_mid_underrun", underrun, 0);
      RESET_N = 1'b1;
      tick();
      chk("rst_after_lb_we", lb_we, 0);
      chk("rst_after_busy", fetch_busy, 0);
      tick();
      chk("rst_after2_lb_we", lb_we, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
